// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, returning result/exception/tag with a ready pulse.
module multdiv_iter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [TAG_W-1:0] tag_in,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int ACC_W = 2 * WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_q, neg_d;
  logic               bzero_q, bzero_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;
  logic [TAG_W-1:0]   tag_out_q, tag_out_d;
  logic               busy_q, busy_d;

  // Unsigned magnitudes; the most-negative value maps to 2^(WIDTH-1), which still fits.
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               start;
  logic [WIDTH:0]     mul_sum;
  logic [ACC_W-1:0]   div_sh;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH:0]     prod_top;
  logic [WIDTH-1:0]   quot_s;

  assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign start = ctrl_MULT | ctrl_DIV;

  // acc holds {upper partial/remainder (WIDTH+1), multiplier/quotient (WIDTH)}.
  assign mul_sum   = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign div_sh    = {acc_q[2*WIDTH-1:0], 1'b0};
  assign div_trial = div_sh[2*WIDTH:WIDTH] - {1'b0, opnd_q};
  assign prod_s    = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
  assign prod_top  = prod_s[2*WIDTH-1:WIDTH-1];
  assign quot_s    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    bzero_d   = bzero_q;
    tag_d     = tag_q;
    result_d  = result_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;
    tag_out_d = tag_out_q;
    busy_d    = busy_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (start) begin
          busy_d  = 1'b1;
          cnt_d   = '0;
          tag_d   = tag_in;
          neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          bzero_d = (data_operandB == '0);
          if (ctrl_MULT) begin
            state_d = S_MUL;
            opnd_d  = mag_a;
            acc_d   = {{(WIDTH+1){1'b0}}, mag_b};
          end else begin
            state_d = S_DIV;
            opnd_d  = mag_b;
            acc_d   = {{(WIDTH+1){1'b0}}, mag_a};
          end
        end
      end
      S_MUL: begin
        if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          rdy_d     = 1'b1;
          busy_d    = 1'b0;
          tag_out_d = tag_q;
          result_d  = prod_s[WIDTH-1:0];
          exc_d     = ~(&prod_top | ~|prod_top);
        end else begin
          acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DIV: begin
        // A zero divisor skips the iterations and finishes on the first cycle.
        if (bzero_q || cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          rdy_d     = 1'b1;
          busy_d    = 1'b0;
          tag_out_d = tag_q;
          result_d  = bzero_q ? '0 : quot_s;
          exc_d     = bzero_q | (~neg_q & acc_q[WIDTH-1]);
        end else begin
          acc_d = div_trial[WIDTH] ? div_sh : {div_trial, div_sh[WIDTH-1:1], 1'b1};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      bzero_q   <= 1'b0;
      tag_q     <= '0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
      tag_out_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      bzero_q   <= bzero_d;
      tag_q     <= tag_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
      tag_out_q <= tag_out_d;
      busy_q    <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign tag_out        = tag_out_q;
  assign busy           = busy_q;

endmodule
